// File: rtl/mem_pkg.sv
// Shared types and default constants for the MEM pipeline stage.
package mem_pkg;

   localparam int unsigned SRAM_ADDR_W_DFLT = 18;
   localparam int unsigned WAIT_CYCLES_DFLT = 2;
   localparam int unsigned MEM_BASE_DFLT    = 1024;

   typedef enum logic [2:0] {IDLE, LO, HI, WAIT, DONE} state_t;

   // EX/MEM pipeline register payload
   typedef struct packed {
      logic        wb_en;
      logic        mem_r_en;
      logic        mem_w_en;
      logic [31:0] alu_result;
      logic [31:0] val_rm;
      logic [3:0]  dest;
   } ex_mem_t;

endpackage

// File: rtl/mem_stage_sram_ctrl.sv
// Multi-cycle 32-bit access over a 16-bit SRAM: low half, high half, wait, done.
module sram_ctrl
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W      = SRAM_ADDR_W_DFLT,
   parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DFLT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              is_write,
   input  logic [ADDR_W-1:0] addr,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   output logic              ready,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [15:0]       sram_dq_out,
   input  logic [15:0]       sram_dq_in,
   output logic              sram_dq_oe,
   output logic              sram_we_n
);

   localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [15:0]      data_lo;
   logic [15:0]      data_hi;

   assign ready = (state == DONE) || ((state == IDLE) && !start);
   assign rdata = {data_hi, data_lo};

   // SRAM pins are registered: they are set up on the edge entering LO/HI
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
         data_lo     <= '0;
         data_hi     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state       <= LO;
                  sram_addr   <= addr;
                  sram_dq_out <= wdata[15:0];
                  sram_dq_oe  <= is_write;
                  sram_we_n   <= ~is_write;
               end
            end
            LO: begin
               state       <= HI;
               sram_addr   <= addr | ADDR_W'(1);
               sram_dq_out <= wdata[31:16];
               if (!is_write) data_lo <= sram_dq_in;
            end
            HI: begin
               state      <= WAIT;
               cnt        <= CNT_W'(WAIT_CYCLES - 1);
               sram_dq_oe <= 1'b0;
               sram_we_n  <= 1'b1;
               if (!is_write) data_hi <= sram_dq_in;
            end
            WAIT: begin
               if (cnt == '0) state <= DONE;
               else           cnt   <= cnt - CNT_W'(1);
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/mem_stage.sv
// MEM stage: EX/MEM register, SRAM access controller, MEM/WB register with bubbles.
module mem_stage
   import mem_pkg::*;
#(
   parameter int unsigned SRAM_ADDR_W = SRAM_ADDR_W_DFLT,
   parameter int unsigned WAIT_CYCLES = WAIT_CYCLES_DFLT,
   parameter int unsigned MEM_BASE    = MEM_BASE_DFLT
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   wb_en_in,
   input  logic                   mem_r_en_in,
   input  logic                   mem_w_en_in,
   input  logic [31:0]            alu_result_in,
   input  logic [31:0]            val_rm_in,
   input  logic [3:0]             dest_in,
   output logic                   ready,
   output logic [31:0]            alu_result_mem,
   output logic [3:0]             dest_mem,
   output logic                   wb_en_mem,
   output logic                   wb_en_out,
   output logic                   mem_r_en_out,
   output logic [31:0]            alu_result_out,
   output logic [31:0]            mem_data_out,
   output logic [3:0]             dest_out,
   output logic [SRAM_ADDR_W-1:0] sram_addr,
   output logic [15:0]            sram_dq_out,
   input  logic [15:0]            sram_dq_in,
   output logic                   sram_dq_oe,
   output logic                   sram_we_n
);

   ex_mem_t                ex_q;
   logic [SRAM_ADDR_W-2:0] pair_idx;
   logic [SRAM_ADDR_W-1:0] lo_addr;
   logic [31:0]            rdata;

   // Byte offset from MEM_BASE (wrapping), 32-bit word index -> pair of 16-bit SRAM words
   assign pair_idx = (SRAM_ADDR_W-1)'((ex_q.alu_result - 32'(MEM_BASE)) >> 2);
   assign lo_addr  = {pair_idx, 1'b0};

   assign alu_result_mem = ex_q.alu_result;
   assign dest_mem       = ex_q.dest;
   assign wb_en_mem      = ex_q.wb_en;

   always_ff @(posedge clk) begin
      if (reset) begin
         ex_q <= '0;
      end else if (ready) begin
         ex_q <= '{wb_en:      wb_en_in,
                   mem_r_en:   mem_r_en_in,
                   mem_w_en:   mem_w_en_in,
                   alu_result: alu_result_in,
                   val_rm:     val_rm_in,
                   dest:       dest_in};
      end
   end

   sram_ctrl #(
      .ADDR_W      (SRAM_ADDR_W),
      .WAIT_CYCLES (WAIT_CYCLES)
   ) u_ctrl (
      .clk         (clk),
      .reset       (reset),
      .start       (ex_q.mem_r_en | ex_q.mem_w_en),
      .is_write    (ex_q.mem_w_en),
      .addr        (lo_addr),
      .wdata       (ex_q.val_rm),
      .rdata       (rdata),
      .ready       (ready),
      .sram_addr   (sram_addr),
      .sram_dq_out (sram_dq_out),
      .sram_dq_in  (sram_dq_in),
      .sram_dq_oe  (sram_dq_oe),
      .sram_we_n   (sram_we_n)
   );

   // MEM/WB register: a frozen cycle inserts a bubble, other fields hold
   always_ff @(posedge clk) begin
      if (reset) begin
         wb_en_out      <= 1'b0;
         mem_r_en_out   <= 1'b0;
         alu_result_out <= '0;
         mem_data_out   <= '0;
         dest_out       <= '0;
      end else if (ready) begin
         wb_en_out      <= ex_q.wb_en;
         mem_r_en_out   <= ex_q.mem_r_en;
         alu_result_out <= ex_q.alu_result;
         mem_data_out   <= rdata;
         dest_out       <= ex_q.dest;
      end else begin
         wb_en_out      <= 1'b0;
         mem_r_en_out   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: SRAM device model, transaction-level reference, directed and random ops.
module tb_mem_stage;

   localparam int W = 2;

   logic        clk, reset;
   logic        wb_en_in, mem_r_en_in, mem_w_en_in;
   logic [31:0] alu_result_in, val_rm_in;
   logic [3:0]  dest_in;
   logic        ready, wb_en_mem, wb_en_out, mem_r_en_out;
   logic [31:0] alu_result_mem, alu_result_out, mem_data_out;
   logic [3:0]  dest_mem, dest_out;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out, sram_dq_in;
   logic        sram_dq_oe, sram_we_n;

   logic        wb2, r2, w2;
   logic [31:0] alu2, val2;
   logic [3:0]  dest2;
   logic        ready2, wb_en_mem2, wb_en_out2, mem_r_en_out2;
   logic [31:0] alu_result_mem2, alu_result_out2, mem_data_out2;
   logic [3:0]  dest_mem2, dest_out2;
   logic [17:0] sram_addr2;
   logic [15:0] sram_dq_out2, sram_dq_in2;
   logic        sram_dq_oe2, sram_we_n2;

   logic [15:0] dev     [0:262143];
   logic [15:0] ref_mem [0:262143];

   int errors = 0;
   int checks = 0;

   mem_stage dut (
      .clk(clk), .reset(reset), .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in),
      .mem_w_en_in(mem_w_en_in), .alu_result_in(alu_result_in), .val_rm_in(val_rm_in),
      .dest_in(dest_in), .ready(ready), .alu_result_mem(alu_result_mem), .dest_mem(dest_mem),
      .wb_en_mem(wb_en_mem), .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out),
      .alu_result_out(alu_result_out), .mem_data_out(mem_data_out), .dest_out(dest_out),
      .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_in(sram_dq_in),
      .sram_dq_oe(sram_dq_oe), .sram_we_n(sram_we_n));

   mem_stage #(.WAIT_CYCLES(1)) dut2 (
      .clk(clk), .reset(reset), .wb_en_in(wb2), .mem_r_en_in(r2),
      .mem_w_en_in(w2), .alu_result_in(alu2), .val_rm_in(val2),
      .dest_in(dest2), .ready(ready2), .alu_result_mem(alu_result_mem2), .dest_mem(dest_mem2),
      .wb_en_mem(wb_en_mem2), .wb_en_out(wb_en_out2), .mem_r_en_out(mem_r_en_out2),
      .alu_result_out(alu_result_out2), .mem_data_out(mem_data_out2), .dest_out(dest_out2),
      .sram_addr(sram_addr2), .sram_dq_out(sram_dq_out2), .sram_dq_in(sram_dq_in2),
      .sram_dq_oe(sram_dq_oe2), .sram_we_n(sram_we_n2));

   assign sram_dq_in  = dev[sram_addr];
   assign sram_dq_in2 = 16'(sram_addr2 ^ 18'h0C3C3);

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [15:0] init_val(int a);
      return 16'((a * 40503) ^ 32'h5A5A);
   endfunction

   // SRAM word index of the low half: (byte offset from 1024) / 4 * 2, wrapped to 18 bits
   function automatic logic [17:0] lo_of(logic [31:0] alu);
      return 18'(((alu - 32'd1024) >> 2) << 1);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // SRAM device: a write lands at the end of a strobe cycle unless reset aborts it
   initial forever begin
      @(posedge clk);
      if (!sram_we_n && !reset) dev[sram_addr] = sram_dq_out;
   end

   // Reference model: an accepted memory op freezes the stage for W+3 cycles;
   // the 2nd and 3rd frozen cycles move the low and high halves.
   typedef struct {
      logic        wb, r, w;
      logic [31:0] alu, val;
      logic [3:0]  dest;
   } ins_t;

   ins_t        m_ex;
   int          m_frz;
   logic [15:0] m_lo, m_hi;
   logic [17:0] m_addr;
   logic        e_wb, e_r, m_valid;
   logic [31:0] e_alu, e_data;
   logic [3:0]  e_dest;

   task automatic model_step();
      logic        rdy;
      logic [17:0] a;
      if (reset) begin
         m_ex = '{0, 0, 0, 0, 0, 0};
         m_frz = 0; m_lo = 0; m_hi = 0; m_addr = 0;
         e_wb = 0; e_r = 0; e_alu = 0; e_data = 0; e_dest = 0;
         m_valid = 1'b1;
         return;
      end
      rdy = (m_frz == 0);
      if (!rdy) begin
         if (m_frz == W + 2 || m_frz == W + 1) begin
            a = lo_of(m_ex.alu) | ((m_frz == W + 1) ? 18'd1 : 18'd0);
            m_addr = a;
            if (m_ex.w)
               ref_mem[a] = (m_frz == W + 1) ? m_ex.val[31:16] : m_ex.val[15:0];
            else if (m_frz == W + 1)
               m_hi = ref_mem[a];
            else
               m_lo = ref_mem[a];
         end
         m_frz--;
         e_wb = 1'b0;
         e_r  = 1'b0;
      end else begin
         e_wb = m_ex.wb; e_r = m_ex.r; e_alu = m_ex.alu; e_dest = m_ex.dest;
         e_data = {m_hi, m_lo};
         m_ex = '{wb_en_in, mem_r_en_in, mem_w_en_in, alu_result_in, val_rm_in, dest_in};
         if (m_ex.r || m_ex.w) m_frz = W + 3;
      end
   endtask

   task automatic compare();
      logic        in_lo, in_hi, wr;
      logic [17:0] ea;
      in_lo = (m_frz == W + 2);
      in_hi = (m_frz == W + 1);
      wr    = m_ex.w && (in_lo || in_hi);
      ea    = in_lo ? lo_of(m_ex.alu) : (in_hi ? (lo_of(m_ex.alu) | 18'd1) : m_addr);
      chk("cyc ready", 32'(ready), 32'(m_frz == 0));
      chk("cyc alu_result_mem", alu_result_mem, m_ex.alu);
      chk("cyc dest_mem", 32'(dest_mem), 32'(m_ex.dest));
      chk("cyc wb_en_mem", 32'(wb_en_mem), 32'(m_ex.wb));
      chk("cyc wb_en_out", 32'(wb_en_out), 32'(e_wb));
      chk("cyc mem_r_en_out", 32'(mem_r_en_out), 32'(e_r));
      chk("cyc alu_result_out", alu_result_out, e_alu);
      chk("cyc dest_out", 32'(dest_out), 32'(e_dest));
      chk("cyc mem_data_out", mem_data_out, e_data);
      chk("cyc sram_we_n", 32'(sram_we_n), 32'(!wr));
      chk("cyc sram_dq_oe", 32'(sram_dq_oe), 32'(wr));
      chk("cyc sram_addr", 32'(sram_addr), 32'(ea));
      if (wr) chk("cyc sram_dq_out", 32'(sram_dq_out), 32'(in_hi ? m_ex.val[31:16] : m_ex.val[15:0]));
   endtask

   initial begin
      m_valid = 1'b0;
      forever begin
         @(posedge clk);
         model_step();
         @(negedge clk);
         if (m_valid) compare();
      end
   end

   task automatic set_in(logic wb, logic r, logic w, logic [31:0] alu, logic [31:0] val,
                         logic [3:0] dest);
      wb_en_in = wb; mem_r_en_in = r; mem_w_en_in = w;
      alu_result_in = alu; val_rm_in = val; dest_in = dest;
   endtask

   // Called at a negedge; returns at the negedge just after the op was accepted
   task automatic issue(logic wb, logic r, logic w, logic [31:0] alu, logic [31:0] val,
                        logic [3:0] dest);
      int n = 0;
      set_in(wb, r, w, alu, val, dest);
      while (ready !== 1'b1 && n < 100) begin n++; @(negedge clk); end
      if (n >= 100) chk("issue timeout", 32'(n), 32'd0);
      @(negedge clk);
      set_in(0, 0, 0, 0, 0, 0);
   endtask

   task automatic count_low(output int n);
      n = 0;
      while (ready !== 1'b1 && n < 100) begin n++; @(negedge clk); end
      if (n >= 100) chk("ready timeout", 32'(n), 32'd0);
   endtask

   initial begin
      int n, n2;
      logic [31:0] alu;
      for (int i = 0; i < 262144; i++) begin
         dev[i] = init_val(i);
         ref_mem[i] = init_val(i);
      end
      dev[2] = 16'h5678; ref_mem[2] = 16'h5678;
      dev[3] = 16'h1234; ref_mem[3] = 16'h1234;
      set_in(0, 0, 0, 0, 0, 0);
      wb2 = 0; r2 = 0; w2 = 0; alu2 = 0; val2 = 0; dest2 = 0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      chk("reset ready", 32'(ready), 32'd1);
      chk("reset sram_we_n", 32'(sram_we_n), 32'd1);
      chk("reset wb_en_out", 32'(wb_en_out), 32'd0);
      chk("reset mem_data_out", mem_data_out, 32'd0);

      // ALU op reaches MEM/WB two edges after entering
      issue(1, 0, 0, 32'h5, 0, 4'd3);
      @(negedge clk);
      chk("alu wb_en_out", 32'(wb_en_out), 32'd1);
      chk("alu alu_result_out", alu_result_out, 32'h5);
      chk("alu dest_out", 32'(dest_out), 32'd3);

      // STR 1024
      issue(0, 0, 1, 32'd1024, 32'hDEADBEEF, 4'd1);
      count_low(n);
      chk("str ready low cycles", 32'(n + 1), 32'd5 + 32'd1);
      @(negedge clk);
      chk("str wb_en_out", 32'(wb_en_out), 32'd0);
      chk("str sram word0", 32'(dev[0]), 32'hBEEF);
      chk("str sram word1", 32'(dev[1]), 32'hDEAD);

      // LDR 1028
      issue(1, 1, 0, 32'd1028, 0, 4'd9);
      count_low(n);
      chk("ldr ready low cycles", 32'(n), 32'd5);
      @(negedge clk);
      chk("ldr mem_data_out", mem_data_out, 32'h12345678);
      chk("ldr mem_r_en_out", 32'(mem_r_en_out), 32'd1);
      chk("ldr dest_out", 32'(dest_out), 32'd9);

      // STR then LDR back to back at 1032
      issue(0, 0, 1, 32'd1032, 32'hCAFEF00D, 4'd2);
      count_low(n);
      chk("b2b ready between", 32'(ready), 32'd1);
      issue(1, 1, 0, 32'd1032, 0, 4'd4);
      chk("b2b single ready cycle", 32'(ready), 32'd0);
      count_low(n2);
      chk("b2b low 1", 32'(n), 32'd5);
      chk("b2b low 2", 32'(n2), 32'd5);
      @(negedge clk);
      chk("b2b ldr data", mem_data_out, 32'hCAFEF00D);

      // Both enables: a write with no read capture
      issue(1, 1, 1, 32'd1048, 32'hA5A55A5A, 4'd7);
      count_low(n);
      @(negedge clk);
      chk("rw mem_data_out keeps last load", mem_data_out, 32'hCAFEF00D);
      chk("rw sram word12", 32'(dev[12]), 32'h5A5A);
      chk("rw sram word13", 32'(dev[13]), 32'hA5A5);

      // Reset during the high-half write of an STR to 1040
      issue(0, 0, 1, 32'd1040, 32'h11112222, 4'd6);
      repeat (2) @(negedge clk);
      chk("abort in HI we_n", 32'(sram_we_n), 32'd0);
      chk("abort in HI addr", 32'(sram_addr), 32'd9);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("abort ready", 32'(ready), 32'd1);
      chk("abort sram_we_n", 32'(sram_we_n), 32'd1);
      chk("abort alu_result_mem", alu_result_mem, 32'd0);
      chk("abort low half written", 32'(dev[8]), 32'h2222);
      chk("abort high half untouched", 32'(dev[9]), 32'(init_val(9)));

      // WAIT_CYCLES=1 instance: 5-cycle latency, 4 frozen
      r2 = 1; alu2 = 32'd1032; dest2 = 4'd5;
      chk("w1 ready before", 32'(ready2), 32'd1);
      @(negedge clk);
      r2 = 0; alu2 = 0; dest2 = 0;
      n = 0;
      while (ready2 !== 1'b1 && n < 100) begin n++; @(negedge clk); end
      chk("w1 ready low cycles", 32'(n), 32'd4);
      @(negedge clk);
      chk("w1 mem_data_out", mem_data_out2, 32'hC3C6C3C7);
      chk("w1 mem_r_en_out", 32'(mem_r_en_out2), 32'd1);
      chk("w1 dest_out", 32'(dest_out2), 32'd5);

      // Random mix of ALU ops, loads, stores and combined enables
      for (int k = 0; k < 300; k++) begin
         int kind;
         kind = $urandom_range(0, 19);
         if ($urandom_range(0, 7) == 0)
            alu = 32'd1024 - 32'(4 * $urandom_range(1, 2));
         else
            alu = 32'd1024 + 32'(4 * $urandom_range(0, 15));
         alu = alu + 32'($urandom_range(0, 3));
         issue(1'($urandom_range(0, 1)), kind inside {[8:13], 19}, kind inside {[14:19]},
               (kind < 8) ? $urandom : alu, $urandom, 4'($urandom_range(0, 15)));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      repeat (10) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage ARM pipeline, directly downstream of the EX stage.
- Contains the EX/MEM pipeline register, a multi-cycle controller for the external 16-bit SRAM, and the MEM/WB pipeline register.
- Each 32-bit LDR/STR takes two 16-bit SRAM transfers plus wait cycles. While an access is in flight, `ready` is held low so that upstream stages freeze.
- Also drives the EX/MEM forwarding value that the EX stage uses as its Alu_result_MEM operand.

Parameters:
- SRAM_ADDR_W, 18, SRAM word-address width.
- WAIT_CYCLES, 2, idle cycles after the high-half transfer before completion (must be ≥1).
- MEM_BASE, 1024, byte address mapped to SRAM address 0.

Ports:
- clk  in  1  clock; all flops on rising edge
- reset  in  1  synchronous, active-high reset
- wb_en_in  in  1  EX write-back enable
- mem_r_en_in  in  1  EX load
- mem_w_en_in  in  1  EX store
- alu_result_in  in  32  EX ALU result (byte address for LDR/STR)
- val_rm_in  in  32  EX store data (forwarded Rm)
- dest_in  in  4  destination register
- ready  out  1  1 = stage can accept; 0 = upstream freeze
- alu_result_mem  out  32  EX/MEM register ALU result (forwarding)
- dest_mem  out  4  EX/MEM register destination (hazard/forwarding)
- wb_en_mem  out  1  EX/MEM register wb_en (hazard/forwarding)
- wb_en_out  out  1  MEM/WB write-back enable
- mem_r_en_out  out  1  MEM/WB load select
- alu_result_out  out  32  MEM/WB ALU result
- mem_data_out  out  32  MEM/WB load data
- dest_out  out  4  MEM/WB destination
- sram_addr  out  SRAM_ADDR_W  SRAM address
- sram_dq_out  out  16  SRAM write data
- sram_dq_in  in  16  SRAM read data, valid during the addressing cycle
- sram_dq_oe  out  1  1 = drive sram_dq_out (write)
- sram_we_n  out  1  SRAM write strobe, active low

Behaviour:
- Reset: every register and output is 0, except sram_we_n=1. FSM state is IDLE. A reset during an access aborts it: the FSM goes to IDLE, no partial write is completed, and sram_we_n=1 on the next cycle.
- EX/MEM register: loads all *_in signals on a clock edge when ready=1; holds when ready=0.
- mem_op = registered mem_r_en | mem_w_en.
- Address computation: off = alu_result_mem − MEM_BASE, modulo 32 bits. Low-half address = {off[SRAM_ADDR_W:2], 0}; high-half address = {off[SRAM_ADDR_W:2], 1}. off[1:0] is ignored.
- FSM states: IDLE, LO, HI, WAIT, DONE.
  - IDLE: if mem_op, go to LO, ready=0. Otherwise stay in IDLE, ready=1.
  - LO: sram_addr = low address. On a write, sram_dq_out = val_rm[15:0], oe=1, we_n=0. On a read, data_lo is captured from sram_dq_in at the edge. Next state HI.
  - HI: same as LO with the high address and val_rm[31:16], capturing data_hi. Next state WAIT; wait counter = WAIT_CYCLES−1.
  - WAIT: counter decrements; go to DONE when it reaches 0.
  - DONE: ready=1. Next state IDLE.
  - Outside LO/HI: sram_we_n=1, oe=0, sram_addr holds its last value.
- ready is combinational from the state and mem_op.
- Latency: non-memory op = 1 cycle in MEM. Memory op = WAIT_CYCLES+4 cycles (6 by default), with ready=0 for WAIT_CYCLES+3 of them.
- MEM/WB register, when ready=1: loads wb_en, mem_r_en, alu_result, dest, and mem_data_out = {data_hi, data_lo} (a read's data is already captured by the DONE cycle).
- MEM/WB register, when ready=0: loads a bubble (wb_en_out=0, mem_r_en_out=0; other fields hold).
- A store never asserts wb_en_out unless wb_en_in was set.
- Back-to-back memory ops: in the DONE cycle the EX/MEM register takes the next instruction. The following cycle is IDLE, which detects the new mem_op and starts it. There is no overlap.
- Both read and write enables set at once: treated as a write (no read capture). The bench checks this case.
- The forwarding outputs always reflect the EX/MEM register, including while frozen.

Decomposition:
- Package mem_pkg: the state enum {IDLE, LO, HI, WAIT, DONE} and default constants (MEM_BASE, SRAM_ADDR_W).
- Sub-module sram_ctrl: FSM, wait counter, address/data drive and read capture. Interface: start, is_write, addr, wdata, rdata, ready.
- The top level holds both pipeline registers and the bubble logic.

Test Plan:
- Assert reset for 2 cycles → all outputs 0, sram_we_n=1, ready=1; an ALU op (wb_en=1, alu_result_in=0x5, dest=3) reaches wb_en_out=1, alu_result_out=0x5, dest_out=3 two edges after entering.
- STR alu_result_in=1024, val_rm_in=0xDEADBEEF → SRAM model sees write addr 0 = 0xBEEF, then addr 1 = 0xDEAD; ready=0 for exactly 5 cycles; wb_en_out stays 0.
- LDR from 1028 with model addr 2=0x5678, addr 3=0x1234 → mem_data_out=0x12345678, mem_r_en_out=1, dest_out correct; one MEM/WB bubble per frozen cycle.
- STR 1032 then LDR 1032, back to back → the second access starts in the cycle after DONE; LDR returns the stored value; ready low 5+5 cycles with a single ready=1 cycle between.
- Reset asserted during the HI state of an STR → next cycle IDLE, ready=1, sram_we_n=1, registers 0; the high-half write does not occur.
- Set WAIT_CYCLES=1 → memory op latency 5 cycles, ready low for 4.
